// File: rtl/decoder_seq_pkg.sv
// Shared types and widths for the sequenced 3-to-8 decoder.
// Optional macro DECODER_SEQ_PARITY_EN enables the code parity check in decoder_seq.
package decoder_seq_pkg;

    localparam int unsigned CODE_W     = 3;
    localparam int unsigned ONEHOT_W   = 8;
    localparam int unsigned HOLD_CNT_W = 8;
    localparam int unsigned GAP_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_par(input logic [CODE_W-1:0] code);
        return ^code;
    endfunction

endpackage

// File: rtl/decoder_seq_dec3to8.sv
// Combinational binary-to-one-hot decoder used by decoder_seq.
module dec3to8
    import decoder_seq_pkg::*;
(
    input  logic [CODE_W-1:0]   code_i,
    output logic [ONEHOT_W-1:0] onehot_o
);

    always_comb begin
        onehot_o         = '0;
        onehot_o[code_i] = 1'b1;
    end

endmodule

// File: rtl/decoder_seq.sv
// Sequenced decoder: each accepted code is driven one-hot for HOLD_CYCLES, then GAP_CYCLES of zeros.
// Define DECODER_SEQ_PARITY_EN to add the code_par input and sticky par_err output.
module decoder_seq
    import decoder_seq_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                blank,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CODE_W-1:0]   code,
`ifdef DECODER_SEQ_PARITY_EN
    input  logic                code_par,
    output logic                par_err,
`endif
    output logic [ONEHOT_W-1:0] d,
    output logic                out_valid,
    output logic                busy
);

    localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_CNT_W-1:0]  GAP_LOAD  =
        GAP_CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

    state_e                state_q, state_d;
    logic [HOLD_CNT_W-1:0] hold_q, hold_d;
    logic [GAP_CNT_W-1:0]  gap_q, gap_d;
    logic [ONEHOT_W-1:0]   d_q, d_d;
    logic                  ov_q, ov_d;
    logic                  perr_q, perr_d;
    logic [ONEHOT_W-1:0]   onehot;
    logic                  take;
    logic                  code_ok;

    dec3to8 u_dec (
        .code_i   (code),
        .onehot_o (onehot)
    );

    assign in_ready = (state_q == IDLE) && !blank;
    assign take     = in_valid && in_ready;

`ifdef DECODER_SEQ_PARITY_EN
    assign code_ok = (code_par == even_par(code));
    assign par_err = perr_q;
`else
    assign code_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        d_d     = d_q;
        ov_d    = ov_q;
        perr_d  = perr_q;
        case (state_q)
            IDLE: begin
                d_d  = '0;
                ov_d = 1'b0;
                if (take) begin
                    if (code_ok) begin
                        state_d = DRIVE;
                        d_d     = onehot;
                        ov_d    = 1'b1;
                        hold_d  = HOLD_LOAD;
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (blank) begin
                    state_d = IDLE;
                    d_d     = '0;
                    ov_d    = 1'b0;
                    hold_d  = '0;
                    gap_d   = '0;
                end else if (hold_q == '0) begin
                    d_d  = '0;
                    ov_d = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q - HOLD_CNT_W'(1);
                end
            end
            GAP: begin
                d_d  = '0;
                ov_d = 1'b0;
                if (blank) begin
                    state_d = IDLE;
                    gap_d   = '0;
                end else if (gap_q == '0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - GAP_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                d_d     = '0;
                ov_d    = 1'b0;
                hold_d  = '0;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            gap_q   <= '0;
            d_q     <= '0;
            ov_q    <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            d_q     <= d_d;
            ov_q    <= ov_d;
            perr_q  <= perr_d;
        end
    end

    assign d         = d_q;
    assign out_valid = ov_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_decoder_seq.sv
// Self-checking bench: two decoder_seq instances (HOLD=4/GAP=1 and HOLD=1/GAP=0) against a timeline model.
module tb_decoder_seq;

    localparam int unsigned HOLD_P [2] = '{4, 1};
    localparam int unsigned GAP_P  [2] = '{1, 0};

    logic            clk = 1'b0;
    logic            rst_n;
    logic [1:0]      blank_s, in_valid_s, rdy_s, ov_s, busy_s;
    logic [1:0]      par_s, err_s;
    logic [1:0][2:0] code_s;
    logic [1:0][7:0] d_s;

    int n_vec = 0;
    int n_err = 0;

    // Model: cycles left non-idle, cycles left showing the word, the word itself.
    int          busy_left [2];
    int          word_left [2];
    logic [7:0]  word      [2];
    logic        err_exp   [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        decoder_seq #(
            .HOLD_CYCLES (HOLD_P[g]),
            .GAP_CYCLES  (GAP_P[g])
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .blank     (blank_s[g]),
            .in_valid  (in_valid_s[g]),
            .in_ready  (rdy_s[g]),
            .code      (code_s[g]),
`ifdef DECODER_SEQ_PARITY_EN
            .code_par  (par_s[g]),
            .par_err   (err_s[g]),
`endif
            .d         (d_s[g]),
            .out_valid (ov_s[g]),
            .busy      (busy_s[g])
        );
    end

`ifndef DECODER_SEQ_PARITY_EN
    assign err_s = '0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            busy_left[i] = 0;
            word_left[i] = 0;
            word[i]      = '0;
            err_exp[i]   = 1'b0;
        end
    endtask

    task automatic model_edge(input int i);
        logic par_ok;
        par_ok = 1'b1;
`ifdef DECODER_SEQ_PARITY_EN
        par_ok = (par_s[i] == ^code_s[i]);
`endif
        if (!rst_n) begin
            busy_left[i] = 0;
            word_left[i] = 0;
            err_exp[i]   = 1'b0;
        end else if (busy_left[i] > 0) begin
            if (blank_s[i]) begin
                busy_left[i] = 0;
                word_left[i] = 0;
            end else begin
                busy_left[i]--;
                if (word_left[i] > 0) word_left[i]--;
            end
        end else if (in_valid_s[i] && !blank_s[i]) begin
            if (par_ok) begin
                busy_left[i] = int'(HOLD_P[i] + GAP_P[i]);
                word_left[i] = int'(HOLD_P[i]);
                word[i]      = 8'd1 << code_s[i];
            end else begin
                err_exp[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("d%0d", i),     32'(d_s[i]),    32'((word_left[i] > 0) ? word[i] : 8'h00));
            check($sformatf("ov%0d", i),    32'(ov_s[i]),   32'(word_left[i] > 0));
            check($sformatf("busy%0d", i),  32'(busy_s[i]), 32'(busy_left[i] > 0));
            check($sformatf("ready%0d", i), 32'(rdy_s[i]),  32'((busy_left[i] == 0) && !blank_s[i]));
`ifdef DECODER_SEQ_PARITY_EN
            check($sformatf("perr%0d", i),  32'(err_s[i]),  32'(err_exp[i]));
`endif
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    task automatic drive(input int i, input logic v, input logic [2:0] c);
        in_valid_s[i] = v;
        code_s[i]     = c;
        par_s[i]      = ^c;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid_s = '0;
        while (busy_s != 2'b00 && n < 40) begin
            cycle();
            n++;
        end
        check("drain_idle", 32'(busy_s), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        blank_s = '0;
        in_valid_s = '0;
        code_s = '0;
        par_s = '0;
        model_reset();
        #3;
        check("rst_d", 32'(d_s), 32'd0);
        check("rst_busy", 32'(busy_s), 32'd0);
        check("rst_ov", 32'(ov_s), 32'd0);
        repeat (2) cycle();
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready", 32'(rdy_s), 32'h3);

        // code 5, HOLD=4 GAP=1: word on cycles 1-4, zero on 5, ready on 6
        drive(0, 1'b1, 3'd5);
        cycle();
        check("c5_d1", 32'(d_s[0]), 32'h20);
        drive(0, 1'b0, 3'd0);
        for (int k = 2; k <= 4; k++) begin
            cycle();
            check("c5_hold", 32'(d_s[0]), 32'h20);
        end
        cycle();
        check("c5_gap_d", 32'(d_s[0]), 32'h00);
        check("c5_gap_busy", 32'(busy_s[0]), 32'd1);
        cycle();
        check("c5_ready6", 32'(rdy_s[0]), 32'd1);

        // back-to-back on HOLD=1 GAP=0 instance
        drive(1, 1'b1, 3'd0);
        cycle();
        check("b2b_d0", 32'(d_s[1]), 32'h01);
        drive(1, 1'b1, 3'd7);
        cycle();
        check("b2b_ready", 32'(rdy_s[1]), 32'd1);
        cycle();
        check("b2b_d7", 32'(d_s[1]), 32'h80);
        drain();

        // blank at DRIVE cycle 2 aborts the word
        drive(0, 1'b1, 3'd3);
        cycle();
        drive(0, 1'b0, 3'd0);
        cycle();
        check("blk_pre", 32'(d_s[0]), 32'h08);
        blank_s[0] = 1'b1;
        drive(0, 1'b1, 3'd6);
        cycle();
        check("blk_d", 32'(d_s[0]), 32'h00);
        check("blk_idle", 32'(busy_s[0]), 32'd0);
        cycle();
        check("blk_noready", 32'(rdy_s[0]), 32'd0);
        blank_s[0] = 1'b0;
        drive(0, 1'b0, 3'd0);
        cycle();

        // new code during DRIVE is ignored
        drive(0, 1'b1, 3'd2);
        cycle();
        drive(0, 1'b1, 3'd6);
        cycle();
        check("ign_d", 32'(d_s[0]), 32'h04);
        drain();

        // asynchronous reset mid-DRIVE
        drive(0, 1'b1, 3'd1);
        cycle();
        drive(0, 1'b0, 3'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_d", 32'(d_s[0]), 32'h00);
        check("arst_ov", 32'(ov_s[0]), 32'd0);
        model_reset();
        cycle();
        rst_n = 1'b1;
        check("arst_ready", 32'(rdy_s[0]), 32'd1);
        repeat (3) cycle();

`ifdef DECODER_SEQ_PARITY_EN
        drive(0, 1'b1, 3'd1);
        par_s[0] = 1'b0;
        cycle();
        check("par_err_set", 32'(err_s[0]), 32'd1);
        check("par_d0", 32'(d_s[0]), 32'h00);
        drive(0, 1'b1, 3'd3);
        par_s[0] = 1'b0;
        cycle();
        check("par_d8", 32'(d_s[0]), 32'h08);
        check("par_sticky", 32'(err_s[0]), 32'd1);
        drain();
`endif

        // randomized traffic on both instances
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                blank_s[i]    = ($urandom_range(0, 7) == 0);
                in_valid_s[i] = $urandom_range(0, 1) == 1;
                code_s[i]     = 3'($urandom_range(0, 7));
                par_s[i]      = (^code_s[i]) ^ ($urandom_range(0, 15) == 0);
            end
            cycle();
        end
        blank_s = '0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_seq.md
DECODER_SEQ -- requirements
Module: decoder_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4, meaning cycles each decoded one-hot word is driven (legal 1..255).
REQ-002 SHALL have parameter GAP_CYCLES, default 1, meaning all-zero cycles between consecutive words (legal 0..15).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port blank  input  1  high forces d to zero and blocks acceptance (same polarity as the encoder's en).
REQ-006 SHALL have port in_valid  input  1  code is presented.
REQ-007 SHALL have port in_ready  output  1  block can accept a code this cycle.
REQ-008 SHALL have port code  input  3  binary index 0..7 to decode.
REQ-009 SHALL have port d  output  8  registered one-hot word, d[code]=1.
REQ-010 SHALL have port out_valid  output  1  d carries a decoded word.
REQ-011 SHALL have port busy  output  1  FSM not in IDLE.

Function
REQ-012 SHALL accept a code only on a cycle where in_valid=1 and in_ready=1; in_ready = (state==IDLE) and blank=0.
REQ-013 SHALL implement FSM states IDLE, DRIVE, GAP, encoded in the shared package.
REQ-014 SHALL, on acceptance in IDLE, move to DRIVE next cycle with d=8'b1<<code, out_valid=1, hold counter loaded HOLD_CYCLES-1.
REQ-015 SHALL latency: d/out_valid valid the first rising edge after the accepting edge (1 cycle).
REQ-016 SHALL in DRIVE decrement counter each cycle; when counter==0 go to GAP if GAP_CYCLES>0, else IDLE.
REQ-017 SHALL in GAP drive d=0, out_valid=0 for exactly GAP_CYCLES cycles, then IDLE.
REQ-018 SHALL keep d exactly one-hot whenever out_valid=1 and d=0 whenever out_valid=0.
REQ-019 SHALL ignore code and in_valid outside IDLE (no queuing; in_ready=0 there).
REQ-020 SHALL, when blank rises in DRIVE or GAP, clear d and out_valid next cycle and return to IDLE (word aborted); in IDLE no acceptance while blank=1.
REQ-021 SHALL, with HOLD_CYCLES=1 and GAP_CYCLES=0, allow back-to-back acceptance every 2 cycles (IDLE, DRIVE alternating).
REQ-022 SHALL use 8-bit hold counter and 4-bit gap counter; no wrap, counters stop at 0.

Reset
REQ-023 SHALL on rst_n=0 immediately force state=IDLE, d=8'h00, out_valid=0, busy=0, counters=0, independent of clk.
REQ-024 SHALL, on reset mid-DRIVE, drop the word with no further output after release.
REQ-025 SHALL present in_ready=1 on the first edge after rst_n deasserts (if blank=0).

Configuration
REQ-026 SHALL support macro DECODER_SEQ_PARITY_EN; when defined adds input code_par (1, even parity over code) and output par_err (1, sticky).
REQ-027 SHALL with DECODER_SEQ_PARITY_EN, on acceptance with parity mismatch, stay in IDLE, not drive d, set par_err until reset.
REQ-028 SHALL without the macro, have no code_par/par_err ports and decode every accepted code.

Structure
REQ-029 SHALL place state enum, CODE_W=3, ONEHOT_W=8, HOLD_CNT_W=8, GAP_CNT_W=4 in package decoder_seq_pkg.
REQ-030 SHALL instantiate one combinational sub-module dec3to8 (code -> one-hot), registered in decoder_seq.

Verification
REQ-031 SHALL cover: reset, code=3'd5 accepted, HOLD=4 GAP=1 -> d=8'h20 out_valid=1 cycles 1-4, d=0 cycle 5, in_ready=1 cycle 6.
REQ-032 SHALL cover: code=0 then code=7 back-to-back with HOLD=1 GAP=0 -> d=8'h01 then 8'h80, acceptance every 2 cycles.
REQ-033 SHALL cover: blank=1 at DRIVE cycle 2 of code=3 -> d=0 next cycle, state IDLE, in_ready stays 0 until blank=0.
REQ-034 SHALL cover: in_valid=1 with new code during DRIVE -> ignored, d unchanged.
REQ-035 SHALL cover: rst_n low mid-DRIVE asynchronously -> d=0, out_valid=0 before next clk edge.
REQ-036 SHALL cover (PARITY_EN): code=3'd1 with code_par=0 -> par_err=1, d stays 0; code=3'd3 code_par=0 -> d=8'h08, par_err still 1.
